// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, one outstanding imem request, one-entry skid buffer; out_* valid one cycle after the response.
// Backpressure: stall holds out_*, a response arriving under stall parks in the skid and fetching pauses until it drains.
module fetch_stage #(
    parameter int          XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            out_valid,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc
);

    typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} state_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } skid_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    skid_t           skid;

    logic            req_fire;
    logic            slot_free;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] pc_next_seq;

    assign imem_req_valid  = (state == REQ);
    assign imem_req_addr   = pc;
    assign req_fire        = imem_req_valid && imem_req_ready;
    assign slot_free       = !out_valid || !stall;
    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
    assign pc_next_seq     = pc + XLEN'(4);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= REQ;
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_instr <= NOP_INSTR;
            out_pc    <= '0;
        end else begin
            if (slot_free) begin
                out_valid <= 1'b0;
                out_instr <= NOP_INSTR;
            end

            case (state)
                REQ: begin
                    if (redirect_valid) begin
                        pc <= redirect_target;
                        // An accepted request still owes us a response; swallow it in DROP.
                        if (req_fire) state <= DROP;
                    end else if (req_fire) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        pc    <= redirect_target;
                        state <= imem_resp_valid ? REQ : DROP;
                    end else if (imem_resp_valid) begin
                        pc <= pc_next_seq;
                        if (slot_free) begin
                            out_valid <= 1'b1;
                            out_instr <= imem_resp_data;
                            out_pc    <= pc;
                            state     <= REQ;
                        end else begin
                            skid  <= '{instr: imem_resp_data, pc: pc};
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc    <= redirect_target;
                        state <= REQ;
                    end else if (slot_free) begin
                        out_valid <= 1'b1;
                        out_instr <= skid.instr;
                        out_pc    <= skid.pc;
                        state     <= REQ;
                    end
                end
                DROP: begin
                    if (redirect_valid) pc <= redirect_target;
                    if (imem_resp_valid) state <= REQ;
                end
                default: state <= REQ;
            endcase

            // Flush wins over stall and over any capture above.
            if (redirect_valid) begin
                out_valid <= 1'b0;
                out_instr <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle table plus stall/skid and reset-mid-fetch sequences.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        stl;
        logic        rd_vld;
        logic [31:0] rd_pc;
        logic        rsp_vld;
        logic [31:0] rsp_dat;
        logic        e_req_vld;
        logic [31:0] e_req_addr;
        logic        e_out_vld;
        logic [31:0] e_out_pc;
        logic [31:0] e_out_instr;
    } vec_t;

    vec_t vecs[25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic erv, input logic [31:0] eaddr,
                              input logic eov, input logic [31:0] epc, input logic [31:0] einstr);
        check({tag, " req_valid"}, 32'(imem_req_valid), 32'(erv));
        check({tag, " req_addr"},  imem_req_addr, eaddr);
        check({tag, " out_valid"}, 32'(out_valid), 32'(eov));
        check({tag, " out_pc"},    out_pc, epc);
        check({tag, " out_instr"}, out_instr, einstr);
    endtask

    task automatic drive(input logic rdy, input logic stl, input logic rv, input logic [31:0] rpc,
                         input logic sv, input logic [31:0] sd);
        imem_req_ready  = rdy;
        stall           = stl;
        redirect_valid  = rv;
        redirect_pc     = rpc;
        imem_resp_valid = sv;
        imem_resp_data  = sd;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //           rdy   stl   rv    rpc            rsp   rdat           erv   eaddr          eov   epc            einstr
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0,         NOP};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'hA5A5_0000, 1'b0, 32'h0,         1'b0, 32'h0,         NOP};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h0,         32'hA5A5_0000};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'hA5A5_0004, 1'b0, 32'h4,         1'b0, 32'h0,         NOP};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h8,         1'b1, 32'h4,         32'hA5A5_0004};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'hA5A5_0008, 1'b0, 32'h8,         1'b0, 32'h4,         NOP};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hC,         1'b1, 32'h8,         32'hA5A5_0008};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'hA5A5_000C, 1'b0, 32'hC,         1'b0, 32'h8,         NOP};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h10,        1'b1, 32'hC,         32'hA5A5_000C};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h10,        1'b0, 32'hC,         NOP};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h100,       1'b0, 32'h0,         1'b0, 32'h10,        1'b0, 32'hC,         NOP};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 32'h100,       1'b0, 32'hC,         NOP};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h100,       1'b0, 32'hC,         NOP};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'hA5A5_0100, 1'b0, 32'h100,       1'b0, 32'hC,         NOP};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h104,       1'b1, 32'h100,       32'hA5A5_0100};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 32'h203,       1'b1, 32'h1234_5678, 1'b0, 32'h104,       1'b0, 32'h100,       NOP};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         1'b1, 32'h200,       1'b0, 32'h100,       NOP};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h100,       NOP};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h5A5A_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h100,       NOP};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'h5A5A_FFFC};
        vecs[20] = '{1'b1, 1'b1, 1'b1, 32'h40,        1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'h5A5A_FFFC};
        vecs[21] = '{1'b0, 1'b0, 1'b1, 32'h80,        1'b0, 32'h0,         1'b0, 32'h40,        1'b0, 32'hFFFF_FFFC, NOP};
        vecs[22] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h80,        1'b0, 32'hFFFF_FFFC, NOP};
        vecs[23] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1111_1111, 1'b1, 32'h80,        1'b0, 32'hFFFF_FFFC, NOP};
        vecs[24] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h80,        1'b0, 32'hFFFF_FFFC, NOP};

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        step();
        reset = 1'b0;
        check_outs("reset", 1'b1, 32'h0, 1'b0, 32'h0, NOP);

        // Nominal fetch, redirects in WAIT/REQ/DROP, PC wrap, resp ignored in REQ.
        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].rdy, vecs[i].stl, vecs[i].rd_vld, vecs[i].rd_pc, vecs[i].rsp_vld, vecs[i].rsp_dat);
            check_outs($sformatf("vec%0d", i), vecs[i].e_req_vld, vecs[i].e_req_addr,
                       vecs[i].e_out_vld, vecs[i].e_out_pc, vecs[i].e_out_instr);
            step();
        end

        // Stall with a second response landing in the skid buffer.
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);           step();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hA5A5_0000);   step();
        check_outs("skid pc0", 1'b1, 32'h4, 1'b1, 32'h0, 32'hA5A5_0000);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);           step();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hA5A5_0004);   step();
        check_outs("skid pc4", 1'b1, 32'h8, 1'b1, 32'h4, 32'hA5A5_0004);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);           step();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hA5A5_0008);   step();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
            check_outs($sformatf("hold%0d", k), 1'b0, 32'hC, 1'b1, 32'h4, 32'hA5A5_0004);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        check_outs("skid drain", 1'b1, 32'hC, 1'b1, 32'h8, 32'hA5A5_0008);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);           step();
        check_outs("skid empty", 1'b0, 32'hC, 1'b0, 32'h8, NOP);

        // Reset in WAIT while stalled with a valid output; late response must be ignored.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hA5A5_000C);   step();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);           step();
        check_outs("pre-reset", 1'b0, 32'h10, 1'b1, 32'hC, 32'hA5A5_000C);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_outs("mid reset", 1'b1, 32'h0, 1'b0, 32'h0, NOP);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h9999_9999);   step();
        check_outs("late resp", 1'b1, 32'h0, 1'b0, 32'h0, NOP);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
